// File: rtl/program_loader.sv
// ============================================================================
// program_loader
// Boot-time byte-stream loader: length header, data bytes, XOR checksum,
// written byte-wise into instruction RAM while the core is held in reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module program_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    input  logic                  restart,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [7:0]            imem_wdata,
    output logic                  core_reset,
    output logic                  load_done,
    output logic                  load_error
);

    localparam logic [16:0] c_MAX_WORDS = 17'(2 ** (ADDR_WIDTH - 2));
    localparam int          c_CNT_W     = ADDR_WIDTH + 2;

    typedef enum logic [2:0] {
        S_LEN_HI = 3'd0,
        S_LEN_LO = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [7:0]           r_len_hi;
    logic [15:0]          r_len;
    logic [7:0]           r_csum;
    logic [c_CNT_W-1:0]   r_byte_cnt;

    logic                 w_accept;
    logic [15:0]          w_len_full;
    logic [c_CNT_W-1:0]   w_cnt_inc;
    logic                 w_last_byte;

    assign w_accept    = rx_valid & rx_ready;
    assign w_len_full  = {r_len_hi, rx_data};
    assign w_cnt_inc   = r_byte_cnt + 1'b1;
    // Byte count is wide enough that LEN*4 never wraps for any legal LEN
    assign w_last_byte = (18'(w_cnt_inc) == {r_len, 2'b00});

    always_comb begin
        rx_ready = 1'b0;
        if (reset) begin
            case (r_state)
                S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: rx_ready = 1'b1;
                default:                            rx_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LEN_HI: begin
                if (w_accept) w_state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    if ({1'b0, w_len_full} > c_MAX_WORDS) w_state_next = S_ERROR;
                    else if (w_len_full == 16'd0)         w_state_next = S_CSUM;
                    else                                  w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept && w_last_byte) w_state_next = S_CSUM;
            end
            S_CSUM: begin
                if (w_accept) w_state_next = (rx_data == r_csum) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (restart) w_state_next = S_LEN_HI;
            end
            default: w_state_next = S_LEN_HI;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= S_LEN_HI;
            r_len_hi   <= 8'd0;
            r_len      <= 16'd0;
            r_csum     <= 8'd0;
            r_byte_cnt <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 8'd0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            imem_we <= 1'b0;
            case (r_state)
                S_LEN_HI: begin
                    if (w_accept) r_len_hi <= rx_data;
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len      <= w_len_full;
                        r_byte_cnt <= '0;
                        r_csum     <= 8'd0;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= r_byte_cnt[ADDR_WIDTH-1:0];
                        imem_wdata <= rx_data;
                        r_csum     <= r_csum ^ rx_data;
                        r_byte_cnt <= w_cnt_inc;
                    end
                end
                default: ;
            endcase
            // Core leaves reset only after a full cycle in DONE, so the final RAM write lands first
            core_reset <= !((r_state == S_DONE) && (w_state_next == S_DONE));
            load_done  <= (w_state_next == S_DONE);
            load_error <= (w_state_next == S_ERROR);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// tb_program_loader
// Scoreboard bench: expected RAM writes are queued as bytes are driven.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;

    localparam int ADDR_WIDTH = 10;

    logic                  clock;
    logic                  reset;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  restart;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [7:0]            imem_wdata;
    logic                  core_reset;
    logic                  load_done;
    logic                  load_error;

    int n_checks = 0;
    int n_errors = 0;

    logic [ADDR_WIDTH+7:0] sb_q[$];

    logic [7:0] prog1 [20] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h02, 8'h82, 8'h93,
                               8'h01, 8'h42, 8'h82, 8'h13, 8'h00, 8'h42, 8'h85, 8'h33,
                               8'h40, 8'h42, 8'h86, 8'h33};

    program_loader #(.ADDR_WIDTH(ADDR_WIDTH)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Every RAM write must match the oldest outstanding expected write
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_value("unexpected_write", {22'd0, imem_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [ADDR_WIDTH+7:0] exp_w;
                exp_w = sb_q.pop_front();
                check_value("wr_addr", {22'd0, imem_addr}, {22'd0, exp_w[ADDR_WIDTH+7:8]});
                check_value("wr_data", {24'd0, imem_wdata}, {24'd0, exp_w[7:0]});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1
    task automatic send(input logic [7:0] b, input bit is_data, input int addr, input bit gap);
        logic [31:0] a;
        a = addr;
        if (is_data) sb_q.push_back({a[ADDR_WIDTH-1:0], b});
        rx_valid = 1'b1;
        rx_data  = b;
        check_value("rx_ready", {31'd0, rx_ready}, 32'd1);
        @(posedge clock); #1;
        rx_valid = 1'b0;
        if (gap) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic load_prog1(input logic [7:0] csum, input bit gap);
        send(8'h00, 1'b0, 0, gap);
        send(8'h05, 1'b0, 0, gap);
        for (int i = 0; i < 20; i++) send(prog1[i], 1'b1, i, gap);
        send(csum, 1'b0, 0, gap);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clock); #1;
        restart = 1'b0;
        check_value("restart_done", {31'd0, load_done}, 32'd0);
        check_value("restart_err", {31'd0, load_error}, 32'd0);
        check_value("restart_crst", {31'd0, core_reset}, 32'd1);
        check_value("restart_rdy", {31'd0, rx_ready}, 32'd1);
    endtask

    task automatic check_done_seq(input string tag);
        check_value({tag, "_done"}, {31'd0, load_done}, 32'd1);
        check_value({tag, "_err"}, {31'd0, load_error}, 32'd0);
        check_value({tag, "_crst_hold"}, {31'd0, core_reset}, 32'd1);
        check_value({tag, "_rdy"}, {31'd0, rx_ready}, 32'd0);
        check_value({tag, "_sb_empty"}, sb_q.size(), 32'd0);
        @(posedge clock); #1;
        check_value({tag, "_crst_fall"}, {31'd0, core_reset}, 32'd0);
    endtask

    task automatic check_error(input string tag);
        check_value({tag, "_err"}, {31'd0, load_error}, 32'd1);
        check_value({tag, "_done"}, {31'd0, load_done}, 32'd0);
        check_value({tag, "_rdy"}, {31'd0, rx_ready}, 32'd0);
        @(posedge clock); #1;
        check_value({tag, "_crst"}, {31'd0, core_reset}, 32'd1);
    endtask

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        restart  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_value("rst_we", {31'd0, imem_we}, 32'd0);
        check_value("rst_addr", {22'd0, imem_addr}, 32'd0);
        check_value("rst_wdata", {24'd0, imem_wdata}, 32'd0);
        check_value("rst_crst", {31'd0, core_reset}, 32'd1);
        check_value("rst_done", {31'd0, load_done}, 32'd0);
        check_value("rst_err", {31'd0, load_error}, 32'd0);
        check_value("rst_rdy", {31'd0, rx_ready}, 32'd0);
        reset = 1'b1;
        #1;

        // Good image
        load_prog1(8'h87, 1'b0);
        check_done_seq("good");
        do_restart();

        // Bad checksum
        load_prog1(8'h00, 1'b0);
        check_error("badcsum");
        do_restart();

        // Oversize length: error on LEN_LO, nothing further accepted
        send(8'h01, 1'b0, 0, 1'b0);
        send(8'h01, 1'b0, 0, 1'b0);
        check_value("oversize_err", {31'd0, load_error}, 32'd1);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            check_value("oversize_rdy", {31'd0, rx_ready}, 32'd0);
            @(posedge clock); #1;
        end
        rx_valid = 1'b0;
        check_value("oversize_err_hold", {31'd0, load_error}, 32'd1);
        do_restart();

        // Zero-length images
        send(8'h00, 1'b0, 0, 1'b0);
        send(8'h00, 1'b0, 0, 1'b0);
        send(8'h00, 1'b0, 0, 1'b0);
        check_done_seq("zero_ok");
        do_restart();
        send(8'h00, 1'b0, 0, 1'b0);
        send(8'h00, 1'b0, 0, 1'b0);
        send(8'h01, 1'b0, 0, 1'b0);
        check_error("zero_bad");
        do_restart();

        // Stalled stream
        load_prog1(8'h87, 1'b1);
        check_value("gap_done", {31'd0, load_done}, 32'd1);
        do_restart();

        // Reset in the middle of data
        send(8'h00, 1'b0, 0, 1'b0);
        send(8'h05, 1'b0, 0, 1'b0);
        for (int i = 0; i < 6; i++) send(prog1[i], 1'b1, i, 1'b0);
        reset = 1'b0;
        @(posedge clock); #1;
        check_value("midrst_we", {31'd0, imem_we}, 32'd0);
        check_value("midrst_addr", {22'd0, imem_addr}, 32'd0);
        check_value("midrst_wdata", {24'd0, imem_wdata}, 32'd0);
        check_value("midrst_crst", {31'd0, core_reset}, 32'd1);
        check_value("midrst_rdy", {31'd0, rx_ready}, 32'd0);
        check_value("midrst_sb", sb_q.size(), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        load_prog1(8'h87, 1'b0);
        check_done_seq("after_rst");

        // Reload a single word over a previously good image
        do_restart();
        send(8'h00, 1'b0, 0, 1'b0);
        check_value("reload_crst0", {31'd0, core_reset}, 32'd1);
        send(8'h01, 1'b0, 0, 1'b0);
        check_value("reload_crst1", {31'd0, core_reset}, 32'd1);
        send(8'h00, 1'b1, 0, 1'b0);
        send(8'h00, 1'b1, 1, 1'b0);
        send(8'h00, 1'b1, 2, 1'b0);
        check_value("reload_crst2", {31'd0, core_reset}, 32'd1);
        send(8'h13, 1'b1, 3, 1'b0);
        send(8'h13, 1'b0, 0, 1'b0);
        check_done_seq("reload");

        repeat (3) @(posedge clock);
        #1;
        check_value("final_sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/program_loader.md
# program_loader

Upstream boot stage for the RV32I core. It receives a program as a byte stream over a valid/ready handshake and writes it byte-by-byte into the core's instruction RAM. It validates the image with a length header and an XOR checksum. It holds the core in reset until a good image is loaded, so the manual byte-poking in simulation becomes a synthesizable boot path.

## Interface
Parameters:
- ADDR_WIDTH, 10: instruction RAM byte-address width. MAX_WORDS = 2**(ADDR_WIDTH-2).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- rx_valid  in  1  stream byte valid.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader can accept a byte this cycle.
- restart  in  1  start a new load from DONE or ERROR.
- imem_we  out  1  instruction RAM byte write enable (registered).
- imem_addr  out  ADDR_WIDTH  byte address (registered).
- imem_wdata  out  8  byte data (registered).
- core_reset  out  1  active-high reset to Core (registered).
- load_done  out  1  image accepted.
- load_error  out  1  image rejected (length or checksum).

## Operation
- Stream format, in order:
  - LEN_HI, then LEN_LO: 16-bit word count, MSB first.
  - LEN*4 data bytes.
  - One checksum byte: the XOR of all data bytes. The length bytes are not included.
- Data byte k (0-based) is written to byte address k. Instruction words are sent MSB first, so bits [31:24] of word i land at address 4i. This matches the core's fetch byte order.
- States and transitions:
  - LEN_HI: on accept, latch the high byte, go to LEN_LO.
  - LEN_LO: on accept, latch the low byte.
    - LEN > MAX_WORDS: go to ERROR.
    - LEN == 0: go to CSUM.
    - Otherwise: go to DATA with byte_cnt=0 and csum=0.
  - DATA: on each accept:
    - issue a write at byte_cnt;
    - csum ^= rx_data;
    - byte_cnt++.
    - On the LEN*4-th byte, go to CSUM.
  - CSUM: on accept, go to DONE if rx_data == csum, else go to ERROR.
  - DONE, ERROR: rx_ready=0. When restart=1 at an edge, go to LEN_HI.
  - restart is ignored in all other states.
- Accept means rx_valid & rx_ready at the rising edge.
  - rx_ready = 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 in DONE and ERROR, and 0 while reset is low.
  - rx_ready does not depend on rx_valid.
- byte_cnt is ADDR_WIDTH+2 bits wide, so the LEN*4 comparison never wraps.
  - imem_addr = byte_cnt[ADDR_WIDTH-1:0].
  - LEN ≤ MAX_WORDS keeps every write in range.
- core_reset = 1 in every state except DONE.
- load_done = 1 only in DONE; load_error = 1 only in ERROR.
- RAM contents are never cleared by this block. A failed or aborted load leaves partial data behind, but the core stays in reset.

## Timing
- Reset values, which apply after any edge with reset=0:
  - state = LEN_HI;
  - imem_we = 0, imem_addr = 0, imem_wdata = 0;
  - core_reset = 1;
  - load_done = 0, load_error = 0;
  - csum = 0, byte_cnt = 0.
- Write latency is 1 cycle. When a data byte is accepted at edge E, imem_we/addr/wdata are valid during the cycle after E, and the RAM captures at edge E+1.
  - imem_we is high for exactly one cycle per accepted data byte.
  - Back-to-back accepts give a continuous imem_we.
- load_done and load_error change on the edge that accepts the CSUM byte.
- core_reset falls one edge after entering DONE. This guarantees that the last RAM write (at the CSUM acceptance edge at the earliest) completes before the core leaves reset.
- After restart=1 at edge R:
  - core_reset, load_done and load_error return to 1, 0 and 0 after R;
  - rx_ready = 1 in the cycle after R.
- Reset mid-load: reset=0 at any edge aborts immediately to the reset values, and any pending registered write is dropped. The next image starts at address 0.
- Stalls: rx_valid=0 for any number of cycles causes no state change and no writes.

## Test plan
- Stream 00 05, then bytes 00 00 00 00 05 02 82 93 01 42 82 13 00 42 85 33 40 42 86 33, then checksum 87 → 20 writes to addresses 0–19 in stream order, load_done=1, core_reset falls one cycle later, load_error=0.
- Same stream with checksum 00 → 20 writes, then load_error=1, core_reset stays 1, rx_ready=0. restart=1 → back in LEN_HI, load_error=0.
- Length 01 01 (257 > 256) with ADDR_WIDTH=10 → ERROR on the LEN_LO edge, no imem_we ever asserted, following bytes not accepted.
- Length 00 00, checksum 00 → DONE with zero writes. Checksum 01 → ERROR.
- The first program with rx_valid toggled every other cycle → identical write sequence with no duplicates. Repeat it with reset=0 after the 6th data byte → all outputs take reset values, and the next full load writes from address 0 and completes with load_done=1.
- After a successful load, restart=1 and load a 1-word image 00 01, 00 00 00 13, checksum 13 → core_reset is 1 for the whole load, address 0–3 are rewritten, load_done=1.
